// File: rtl/mem_to_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mem_to_reg_bridge
// Purpose  : Converts a req/gnt memory-style port into a single-outstanding
//            register-bus access with a one-cycle response strobe and an
//            optional access timeout.
// Revision : 1.0 - initial release
// ============================================================================

package mem_to_reg_bridge_pkg;

   // Default register-bus request, sized for the default 48-bit address and 32-bit data path
   typedef struct packed {
      logic [47:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   // Default register-bus response, sized for the default 32-bit data path
   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;

endpackage

module mem_to_reg_bridge #(
   parameter int unsigned AddrWidth     = 48,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = 1024,
   parameter type         req_t         = mem_to_reg_bridge_pkg::reg_req_t,
   parameter type         rsp_t         = mem_to_reg_bridge_pkg::reg_rsp_t
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   mem_req_i,
   input  logic [AddrWidth-1:0]   mem_addr_i,
   input  logic                   mem_we_i,
   input  logic [DataWidth-1:0]   mem_wdata_i,
   input  logic [DataWidth/8-1:0] mem_be_i,
   output logic                   mem_gnt_o,
   output logic                   mem_rsp_valid_o,
   output logic [DataWidth-1:0]   mem_rsp_rdata_o,
   output logic                   mem_rsp_error_o,
   output req_t                   reg_req_o,
   input  rsp_t                   reg_rsp_i
);

   // The counter only ever needs to reach TimeoutCycles-1 before the abort fires
   localparam int unsigned CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [CntWidth-1:0] CntLast =
      CntWidth'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);
   localparam logic [CntWidth-1:0] CntMax = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [AddrWidth-1:0]   r_addr;
   logic                   r_we;
   logic [DataWidth-1:0]   r_wdata;
   logic [DataWidth/8-1:0] r_be;
   logic [DataWidth-1:0]   r_rdata;
   logic                   r_error;
   logic [CntWidth-1:0]    r_cnt;
   logic                   w_gnt;
   logic                   w_timeout;

   // A grant is only possible while not waiting on the bus; reset masks it
   // because the asynchronously-cleared state alone would let it follow mem_req_i.
   assign w_gnt     = rst_ni && mem_req_i && (r_state != ISSUE);
   assign w_timeout = (TimeoutCycles != 0) && (r_cnt == CntLast);

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Request capture on grant; response capture on ready or timeout abort
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_be    <= '0;
         r_rdata <= '0;
         r_error <= 1'b0;
      end else begin
         if (w_gnt) begin
            r_addr  <= mem_addr_i;
            r_we    <= mem_we_i;
            r_wdata <= mem_wdata_i;
            r_be    <= mem_be_i;
         end
         if (r_state == ISSUE) begin
            if (reg_rsp_i.ready) begin
               // Writes never return data, even when the slave drives some
               r_rdata <= r_we ? '0 : reg_rsp_i.rdata;
               r_error <= reg_rsp_i.error;
            end else if (w_timeout) begin
               r_rdata <= '0;
               r_error <= 1'b1;
            end
         end
      end
   end

   // Timeout counter: restarts with each access, saturates instead of wrapping
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (w_gnt) begin
         r_cnt <= '0;
      end else if ((r_state == ISSUE) && !reg_rsp_i.ready && (r_cnt != CntMax)) begin
         r_cnt <= r_cnt + CntWidth'(1);
      end
   end

   // Next-state and output decode; ready takes priority over the timeout
   always_comb begin
      w_state_next    = r_state;
      mem_gnt_o       = w_gnt;
      mem_rsp_valid_o = 1'b0;
      mem_rsp_rdata_o = '0;
      mem_rsp_error_o = 1'b0;
      reg_req_o       = '0;
      case (r_state)
         IDLE: begin
            if (w_gnt) w_state_next = ISSUE;
         end
         ISSUE: begin
            reg_req_o.valid = 1'b1;
            reg_req_o.addr  = r_addr;
            reg_req_o.write = r_we;
            reg_req_o.wdata = r_wdata;
            reg_req_o.wstrb = r_be;
            if (reg_rsp_i.ready || w_timeout) w_state_next = RESP;
         end
         RESP: begin
            mem_rsp_valid_o = 1'b1;
            mem_rsp_rdata_o = r_rdata;
            mem_rsp_error_o = r_error;
            w_state_next    = w_gnt ? ISSUE : IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_to_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_to_reg_bridge
// Purpose  : Self-checking bench for mem_to_reg_bridge (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_to_reg_bridge;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        mem_req;
   logic [47:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;
   logic        mem_rsp_error;
   mem_to_reg_bridge_pkg::reg_req_t reg_req;
   mem_to_reg_bridge_pkg::reg_rsp_t reg_rsp;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_to_reg_bridge #(
      .AddrWidth     (48),
      .DataWidth     (32),
      .TimeoutCycles (TMO)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .mem_req_i       (mem_req),
      .mem_addr_i      (mem_addr),
      .mem_we_i        (mem_we),
      .mem_wdata_i     (mem_wdata),
      .mem_be_i        (mem_be),
      .mem_gnt_o       (mem_gnt),
      .mem_rsp_valid_o (mem_rsp_valid),
      .mem_rsp_rdata_o (mem_rsp_rdata),
      .mem_rsp_error_o (mem_rsp_error),
      .reg_req_o       (reg_req),
      .reg_rsp_i       (reg_rsp)
   );

   // One complete access. ready_at = ISSUE cycle (1-based) on which the slave
   // answers; 0 or anything beyond TMO means the slave never answers in time.
   task automatic do_access(input string name, input logic we, input logic [47:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input int ready_at, input logic [31:0] sl_rdata,
                            input logic sl_err);
      int          exp_cycles;
      logic        exp_err;
      logic [31:0] exp_rdata;
      if (ready_at >= 1 && ready_at <= TMO) begin
         exp_cycles = ready_at;
         exp_err    = sl_err;
         exp_rdata  = we ? 32'h0 : sl_rdata;
      end else begin
         exp_cycles = TMO;
         exp_err    = 1'b1;
         exp_rdata  = 32'h0;
      end
      @(negedge clk);
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_be = be;
      reg_rsp = '0;
      #1;
      n_tests++;
      if (mem_gnt !== 1'b1 || reg_req.valid !== 1'b0 || mem_rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s grant: gnt=%b regvalid=%b rvalid=%b required 1 0 0",
                  name, mem_gnt, reg_req.valid, mem_rsp_valid);
      end
      @(negedge clk);
      for (int c = 1; c <= exp_cycles; c++) begin
         mem_req   = 1'($urandom_range(0, 1));
         mem_addr  = {$urandom(), $urandom()};
         mem_we    = 1'($urandom_range(0, 1));
         mem_wdata = $urandom();
         mem_be    = 4'($urandom());
         reg_rsp.ready = (c == ready_at);
         reg_rsp.rdata = (c == ready_at) ? sl_rdata : $urandom();
         reg_rsp.error = (c == ready_at) ? sl_err : 1'($urandom_range(0, 1));
         #1;
         n_tests++;
         if (reg_req.valid !== 1'b1 || reg_req.addr !== addr || reg_req.write !== we ||
             reg_req.wdata !== wdata || reg_req.wstrb !== be || mem_gnt !== 1'b0 ||
             mem_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s issue c%0d: v=%b a=%h w=%b d=%h s=%h gnt=%b rv=%b required 1 %h %b %h %h 0 0",
                     name, c, reg_req.valid, reg_req.addr, reg_req.write, reg_req.wdata,
                     reg_req.wstrb, mem_gnt, mem_rsp_valid, addr, we, wdata, be);
         end
         @(negedge clk);
      end
      mem_req = 1'b0;
      reg_rsp = '0;
      reg_rsp.rdata = $urandom();
      #1;
      n_tests++;
      if (mem_rsp_valid !== 1'b1 || mem_rsp_rdata !== exp_rdata ||
          mem_rsp_error !== exp_err || reg_req !== '0) begin
         n_fail++;
         $display("FAIL %s resp: rv=%b rdata=%h err=%b regvalid=%b required 1 %h %b 0",
                  name, mem_rsp_valid, mem_rsp_rdata, mem_rsp_error, reg_req.valid,
                  exp_rdata, exp_err);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (mem_rsp_valid !== 1'b0 || mem_rsp_rdata !== 32'h0 || mem_rsp_error !== 1'b0 ||
          reg_req !== '0 || mem_gnt !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle: rv=%b rdata=%h err=%b regvalid=%b gnt=%b required all 0",
                  name, mem_rsp_valid, mem_rsp_rdata, mem_rsp_error, reg_req.valid, mem_gnt);
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; mem_req = 1'b1; mem_addr = 48'h1; mem_we = 1'b1;
      mem_wdata = 32'hFFFF_FFFF; mem_be = 4'hF;
      reg_rsp = '0; reg_rsp.ready = 1'b1; reg_rsp.rdata = 32'hA5A5_A5A5;
      #1;
      n_tests++;
      if (mem_gnt !== 1'b0 || mem_rsp_valid !== 1'b0 || mem_rsp_rdata !== 32'h0 ||
          mem_rsp_error !== 1'b0 || reg_req !== '0) begin
         n_fail++;
         $display("FAIL reset: gnt=%b rv=%b rdata=%h err=%b req=%h required all 0",
                  mem_gnt, mem_rsp_valid, mem_rsp_rdata, mem_rsp_error, reg_req);
      end
      repeat (2) @(negedge clk);
      rst_ni = 1'b1; mem_req = 1'b0; reg_rsp = '0;
      #1;
      n_tests++;
      if (mem_gnt !== 1'b0 || mem_rsp_valid !== 1'b0 || reg_req !== '0) begin
         n_fail++;
         $display("FAIL reset_release: gnt=%b rv=%b regvalid=%b required 0 0 0",
                  mem_gnt, mem_rsp_valid, reg_req.valid);
      end
   endtask

   task automatic test_read_fast();
      do_access("read_fast", 1'b0, 48'h1000, $urandom(), 4'hF, 1, 32'hDEAD_BEEF, 1'b0);
   endtask

   task automatic test_write_slow();
      do_access("write_slow", 1'b1, 48'h2004, 32'h1234_5678, 4'hF, 5, 32'hCAFE_F00D, 1'b0);
   endtask

   task automatic test_timeout();
      do_access("timeout_rd", 1'b0, 48'h3000, 32'h0, 4'hF, 0, 32'h1111_2222, 1'b0);
      do_access("timeout_wr", 1'b1, 48'h3008, 32'h5555_AAAA, 4'h3, 0, 32'h0, 1'b0);
   endtask

   task automatic test_slave_error();
      do_access("slverr_rd", 1'b0, 48'h4000, 32'h0, 4'hF, 3, 32'h7777_8888, 1'b1);
      do_access("slverr_wr", 1'b1, 48'h4004, 32'h9999_0000, 4'hC, 2, 32'hBBBB_CCCC, 1'b1);
   endtask

   task automatic test_ready_on_timeout();
      do_access("ready_last", 1'b0, 48'h5000, 32'h0, 4'hF, TMO, 32'h0BAD_CAFE, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [47:0] a0, a1;
      logic [31:0] r0, r1;
      a0 = 48'h6000; a1 = 48'h6004; r0 = $urandom(); r1 = $urandom();
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = a0; mem_be = 4'hF;
      reg_rsp = '0; reg_rsp.ready = 1'b1; reg_rsp.rdata = r0;
      #1;
      n_tests++;
      if (mem_gnt !== 1'b1) begin
         n_fail++; $display("FAIL b2b c0 gnt: got %b required 1", mem_gnt);
      end
      @(negedge clk);
      mem_addr = a1;
      #1;
      n_tests++;
      if (mem_gnt !== 1'b0 || reg_req.valid !== 1'b1 || reg_req.addr !== a0) begin
         n_fail++;
         $display("FAIL b2b c1: gnt=%b v=%b a=%h required 0 1 %h", mem_gnt, reg_req.valid,
                  reg_req.addr, a0);
      end
      @(negedge clk);
      reg_rsp.rdata = r1;
      #1;
      n_tests++;
      if (mem_rsp_valid !== 1'b1 || mem_rsp_rdata !== r0 || mem_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b c2: rv=%b rdata=%h gnt=%b required 1 %h 1", mem_rsp_valid,
                  mem_rsp_rdata, mem_gnt, r0);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (mem_gnt !== 1'b0 || reg_req.valid !== 1'b1 || reg_req.addr !== a1) begin
         n_fail++;
         $display("FAIL b2b c3: gnt=%b v=%b a=%h required 0 1 %h", mem_gnt, reg_req.valid,
                  reg_req.addr, a1);
      end
      @(negedge clk);
      mem_req = 1'b0;
      #1;
      n_tests++;
      if (mem_rsp_valid !== 1'b1 || mem_rsp_rdata !== r1 || mem_gnt !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b c4: rv=%b rdata=%h gnt=%b required 1 %h 0", mem_rsp_valid,
                  mem_rsp_rdata, mem_gnt, r1);
      end
      @(negedge clk);
      reg_rsp = '0;
      #1;
      n_tests++;
      if (mem_rsp_valid !== 1'b0 || reg_req.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b c5: rv=%b v=%b required 0 0", mem_rsp_valid, reg_req.valid);
      end
   endtask

   task automatic test_reset_mid_issue();
      int stray;
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 48'h7000; mem_be = 4'hF; reg_rsp = '0;
      @(negedge clk);
      mem_req = 1'b0;
      @(negedge clk);
      #1;
      n_tests++;
      if (reg_req.valid !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid pre: regvalid=%b required 1", reg_req.valid);
      end
      #1;
      rst_ni = 1'b0; mem_req = 1'b1;
      #1;
      n_tests++;
      if (reg_req.valid !== 1'b0 || mem_rsp_valid !== 1'b0 || mem_gnt !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid assert: regvalid=%b rv=%b gnt=%b required 0 0 0",
                  reg_req.valid, mem_rsp_valid, mem_gnt);
      end
      @(negedge clk);
      rst_ni = 1'b1; mem_req = 1'b0;
      stray = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (mem_rsp_valid !== 1'b0 || reg_req.valid !== 1'b0) stray++;
         @(negedge clk);
      end
      n_tests++;
      if (stray != 0) begin
         n_fail++; $display("FAIL rst_mid stray: %0d active cycles required 0", stray);
      end
      do_access("rst_mid_next", 1'b0, 48'h7004, 32'h0, 4'hF, 2, 32'h600D_600D, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         do_access("random", 1'($urandom_range(0, 1)), {$urandom(), $urandom()}, $urandom(),
                   4'($urandom()), $urandom_range(0, TMO + 3), $urandom(),
                   1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      rst_ni = 1'b0; mem_req = 1'b0; mem_addr = '0; mem_we = 1'b0;
      mem_wdata = '0; mem_be = '0; reg_rsp = '0;
      test_reset();
      test_read_fast();
      test_write_slow();
      test_timeout();
      test_slave_error();
      test_ready_on_timeout();
      test_back_to_back();
      test_reset_mid_issue();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_to_reg_bridge.md
MEM_TO_REG_BRIDGE -- requirements
Module: mem_to_reg_bridge

Interface
REQ-001 Parameter AddrWidth, default 48: width of the memory-side and register-bus address.
REQ-002 Parameter DataWidth, default 32: width of the data path; must be a multiple of 8.
REQ-003 Parameter TimeoutCycles, default 1024: maximum number of ISSUE cycles before the access is aborted; 0 disables the timeout.
REQ-004 Parameter req_t, default logic: register-bus request struct (addr, write, wdata, wstrb, valid).
REQ-005 Parameter rsp_t, default logic: register-bus response struct (rdata, error, ready).
REQ-006 Ports, in order:
- clk_i  in  1  clock; all state on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- mem_req_i  in  1  memory request, held high until granted.
- mem_addr_i  in  AddrWidth  byte address.
- mem_we_i  in  1  1 = write, 0 = read.
- mem_wdata_i  in  DataWidth  write data.
- mem_be_i  in  DataWidth/8  byte enables.
- mem_gnt_o  out  1  request accepted this cycle.
- mem_rsp_valid_o  out  1  single-cycle response strobe; no backpressure.
- mem_rsp_rdata_o  out  DataWidth  read data.
- mem_rsp_error_o  out  1  access error.
- reg_req_o  out  req_t  register-bus request.
- reg_rsp_i  in  rsp_t  register-bus response.

Function
REQ-007 The FSM SHALL have three states: IDLE, ISSUE, RESP.
REQ-008 In IDLE and RESP, mem_gnt_o SHALL equal mem_req_i combinationally.
- Grant captures addr, we, wdata and be into registers.
- Grant moves the FSM to ISSUE on the next edge.
REQ-009 In ISSUE, mem_gnt_o SHALL be 0.
REQ-010 In ISSUE, reg_req_o.valid SHALL be 1, with addr, write, wdata and wstrb driven only from the captured registers.
REQ-011 Outside ISSUE, reg_req_o SHALL be all zero.
REQ-012 In ISSUE with reg_rsp_i.ready=1, the block SHALL:
- capture rdata (reads) or zero (writes) and reg_rsp_i.error;
- move to RESP.
REQ-013 In RESP, mem_rsp_valid_o SHALL be 1 for exactly one cycle with the captured rdata and error.
- Without a new grant, the FSM returns to IDLE.
- With a new grant, the FSM moves directly to ISSUE.
REQ-014 mem_rsp_valid_o SHALL be 0 in IDLE and ISSUE; mem_rsp_rdata_o and mem_rsp_error_o SHALL be 0 whenever mem_rsp_valid_o=0.
REQ-015 Latency: grant at cycle t and ready at cycle t+k (k>=1) SHALL give mem_rsp_valid_o at cycle t+k+1.
- Minimum latency is 2 cycles.
- Peak throughput is one access per 2 cycles.
REQ-016 The timeout counter SHALL:
- clear on every entry to ISSUE;
- increment each ISSUE cycle without ready;
- saturate, never wrap.
REQ-017 If TimeoutCycles>0 and the counter reaches TimeoutCycles-1 with ready still 0, the block SHALL, at the next edge:
- drop valid;
- enter RESP with error=1 and rdata=0.
REQ-018 If ready and timeout occur in the same cycle, ready SHALL win: normal completion, no error.
REQ-019 At most one access SHALL be outstanding; mem_* inputs SHALL be ignored while not granting.
REQ-020 Error on a write SHALL still return rdata=0 with error=1.

Reset
REQ-021 When rst_ni=0 (asynchronous), the block SHALL:
- force IDLE and clear the counter and all captured registers;
- drive mem_gnt_o=0 only while rst_ni=0, and mem_rsp_valid_o=0, mem_rsp_rdata_o=0, mem_rsp_error_o=0, reg_req_o all zero.
REQ-022 Reset during ISSUE SHALL deassert reg_req_o.valid immediately with no response strobe; the first access after reset SHALL behave as from IDLE.

Verification
REQ-023 Read, ready in first ISSUE cycle: addr 0x1000, reg rdata 0xDEADBEEF -> reg valid cycle 1, rvalid cycle 2, rdata 0xDEADBEEF, error 0.
REQ-024 Write, ready after 5 cycles: addr 0x2004, wdata 0x12345678, be 0xF -> reg write=1, wstrb 0xF held stable for 5 cycles, rvalid 1 cycle later, rdata 0, error 0.
REQ-025 Back-to-back: mem_req_i held high for two reads, ready always 1 -> grants at cycles 0 and 2, rvalids at cycles 2 and 4.
REQ-026 Timeout: TimeoutCycles=8, ready never asserted -> valid high exactly 8 cycles, then rvalid with error=1, rdata=0, FSM back in IDLE.
REQ-027 Slave error plus simultaneous-event check:
- reg error=1 with ready -> mem_rsp_error_o=1.
- ready on the timeout cycle -> error=0.
REQ-028 Reset mid-ISSUE: assert rst_ni=0 during wait -> reg valid low the same cycle, no rvalid; next request completes normally.
